// File: rtl/bp_me_pkg.sv
// Shared types for the CCE LCE-request receive path: processor configuration
// selection, BedRock message enums, the decoded CCE request type and the
// receive FSM states.
package bp_me_pkg;

  localparam int dword_width_gp = 64;

  typedef enum logic [1:0] {
    e_bp_default_cfg   = 2'd0,
    e_bp_dual_core_cfg = 2'd1
  } bp_params_e;

  typedef enum logic {
    e_cce_mode_normal   = 1'b0,
    e_cce_mode_uncached = 1'b1
  } bp_cce_mode_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef enum logic [1:0] {
    e_bedrock_req_rd_miss = 2'd0,
    e_bedrock_req_wr_miss = 2'd1,
    e_bedrock_req_uc_rd   = 2'd2,
    e_bedrock_req_uc_wr   = 2'd3
  } bp_bedrock_lce_req_type_e;

  typedef enum logic [1:0] {
    e_req_rd_miss = 2'd0,
    e_req_wr_miss = 2'd1,
    e_req_uc_rd   = 2'd2,
    e_req_uc_wr   = 2'd3
  } bp_cce_req_type_e;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_ready = 2'd1,
    e_error = 2'd2
  } bp_cce_lce_req_rx_state_e;

  function automatic int cfg_num_lce(bp_params_e p);
    return (p == e_bp_dual_core_cfg) ? 2 : 4;
  endfunction

  function automatic int cfg_paddr_width(bp_params_e p);
    return (p == e_bp_dual_core_cfg) ? 40 : 40;
  endfunction

  function automatic int cfg_block_width(bp_params_e p);
    return (p == e_bp_dual_core_cfg) ? 256 : 512;
  endfunction

  function automatic int cfg_lce_assoc(bp_params_e p);
    return (p == e_bp_dual_core_cfg) ? 4 : 8;
  endfunction

  function automatic int cfg_lce_id_width(bp_params_e p);
    return (cfg_num_lce(p) > 1) ? $clog2(cfg_num_lce(p)) : 1;
  endfunction

  function automatic int cfg_lru_way_width(bp_params_e p);
    return (cfg_lce_assoc(p) > 1) ? $clog2(cfg_lce_assoc(p)) : 1;
  endfunction

  // Header layout, MSB first: msg_type, addr, size, lce_id, lru_way, non_excl
  function automatic int cfg_lce_req_header_width(bp_params_e p);
    return 2 + cfg_paddr_width(p) + 3 + cfg_lce_id_width(p) + cfg_lru_way_width(p) + 1;
  endfunction

  // BedRock size code for a block of the given width in bits (code = log2 bytes)
  function automatic bp_bedrock_msg_size_e block_msg_size(int block_width);
    return bp_bedrock_msg_size_e'(3'($clog2(block_width / 8)));
  endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with ready-and-valid input and valid-then-yumi output.
// No bypass: a full FIFO stays not-ready even in a cycle that dequeues.
module bsg_two_fifo
  #(parameter int width_p = 8)
  (input  logic               clk_i
  ,input  logic               reset_i
  ,output logic               ready_and_o
  ,input  logic [width_p-1:0] data_i
  ,input  logic               v_i
  ,output logic               v_o
  ,output logic [width_p-1:0] data_o
  ,input  logic               yumi_i
  );

  logic [1:0][width_p-1:0] mem_r;
  logic                    head_r, tail_r;
  logic [1:0]              count_r;
  logic                    enq, deq;

  assign ready_and_o = (count_r != 2'd2);
  assign v_o         = (count_r != 2'd0);
  assign data_o      = mem_r[head_r];
  assign enq         = v_i & ready_and_o;
  assign deq         = yumi_i & v_o;

  // Pointer and occupancy tracking
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) tail_r <= ~tail_r;
      if (deq) head_r <= ~head_r;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  // Storage write; contents are don't-care until marked valid
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[tail_r] <= data_i;
  end

endmodule

// File: rtl/bp_cce_lce_req_rx.sv
// CCE LCE-request receiver: buffers BedRock LCE requests, decodes the head,
// blocks cached requests from an LCE that already has a coherent transaction
// in flight, and drops malformed cached requests while raising a sticky error.
// Optional build macro BP_CCE_LCE_REQ_RX_STATS_EN adds per-type issue counters
// on stat_counts_o.
module bp_cce_lce_req_rx
  import bp_me_pkg::*;
  #(parameter bp_params_e bp_params_p   = e_bp_default_cfg
   ,parameter int         block_width_p = cfg_block_width(bp_params_p)
   )
  (input  logic                                                 clk_i
  ,input  logic                                                 reset_i
  ,input  bp_cce_mode_e                                         cce_mode_i
  ,input  logic [cfg_lce_req_header_width(bp_params_p)-1:0]     lce_req_header_i
  ,input  logic [cfg_block_width(bp_params_p)-1:0]              lce_req_data_i
  ,input  logic                                                 lce_req_v_i
  ,output logic                                                 lce_req_ready_and_o
  ,output logic                                                 req_v_o
  ,input  logic                                                 req_yumi_i
  ,output bp_cce_req_type_e                                     req_type_o
  ,output logic [cfg_lce_id_width(bp_params_p)-1:0]             req_lce_id_o
  ,output logic [cfg_paddr_width(bp_params_p)-1:0]              req_addr_o
  ,output bp_bedrock_msg_size_e                                 req_size_o
  ,output logic [cfg_lru_way_width(bp_params_p)-1:0]            req_lru_way_o
  ,output logic                                                 req_non_excl_o
  ,output logic [dword_width_gp-1:0]                            req_data_o
  ,input  logic                                                 pending_clear_v_i
  ,input  logic [cfg_lce_id_width(bp_params_p)-1:0]             pending_clear_lce_i
  ,output logic                                                 error_o
`ifdef BP_CCE_LCE_REQ_RX_STATS_EN
  ,output logic [3:0][31:0]                                     stat_counts_o
`endif
  );

  localparam int num_lce_lp              = cfg_num_lce(bp_params_p);
  localparam int paddr_width_lp          = cfg_paddr_width(bp_params_p);
  localparam int lce_id_width_lp         = cfg_lce_id_width(bp_params_p);
  localparam int lru_way_width_lp        = cfg_lru_way_width(bp_params_p);
  localparam int lce_req_header_width_lp = cfg_lce_req_header_width(bp_params_p);
  localparam int cce_block_width_lp      = cfg_block_width(bp_params_p);
  localparam int fifo_width_lp           = lce_req_header_width_lp + dword_width_gp;
  localparam bp_bedrock_msg_size_e block_size_lp = block_msg_size(block_width_p);

  typedef struct packed {
    bp_bedrock_lce_req_type_e          msg_type;
    logic [paddr_width_lp-1:0]         addr;
    bp_bedrock_msg_size_e              size;
    logic [lce_id_width_lp-1:0]        lce_id;
    logic [lru_way_width_lp-1:0]       lru_way;
    logic                              non_excl;
  } lce_req_header_s;

  bp_cce_lce_req_rx_state_e state_r, state_n;

  logic [fifo_width_lp-1:0]  fifo_data;
  logic                      fifo_ready, fifo_v, fifo_yumi;
  lce_req_header_s           head;
  logic [dword_width_gp-1:0] head_data;

  logic                      head_cached, head_error, clear_hits_head, blocked;
  logic                      issue, error_set, error_r;
  logic [num_lce_lp-1:0]     pending_r, pending_set, pending_clr;

  // Only the low dword of the request data travels with the message
  logic unused_data_hi;
  assign unused_data_hi = ^lce_req_data_i[cce_block_width_lp-1:dword_width_gp];

  assign lce_req_ready_and_o = fifo_ready & (state_r != e_reset);

  bsg_two_fifo
   #(.width_p(fifo_width_lp))
   req_fifo
    (.clk_i
    ,.reset_i
    ,.ready_and_o (fifo_ready)
    ,.data_i      ({lce_req_header_i, lce_req_data_i[dword_width_gp-1:0]})
    ,.v_i         (lce_req_v_i & lce_req_ready_and_o)
    ,.v_o         (fifo_v)
    ,.data_o      (fifo_data)
    ,.yumi_i      (fifo_yumi)
    );

  assign head      = lce_req_header_s'(fifo_data[fifo_width_lp-1:dword_width_gp]);
  assign head_data = fifo_data[dword_width_gp-1:0];

  // Head decode: classify, check for malformed cached requests, and apply
  // the pending block with a same-cycle bypass of the completion clear
  always_comb begin
    head_cached     = (head.msg_type == e_bedrock_req_rd_miss)
                    | (head.msg_type == e_bedrock_req_wr_miss);
    head_error      = head_cached
                    & ((head.size != block_size_lp) | (cce_mode_i == e_cce_mode_uncached));
    clear_hits_head = pending_clear_v_i & (pending_clear_lce_i == head.lce_id);
    blocked         = head_cached & pending_r[head.lce_id] & ~clear_hits_head;
    req_type_o      = e_req_rd_miss;
    unique case (head.msg_type)
      e_bedrock_req_rd_miss: req_type_o = e_req_rd_miss;
      e_bedrock_req_wr_miss: req_type_o = e_req_wr_miss;
      e_bedrock_req_uc_rd:   req_type_o = e_req_uc_rd;
      e_bedrock_req_uc_wr:   req_type_o = e_req_uc_wr;
      default:               req_type_o = e_req_rd_miss;
    endcase
  end

  assign req_lce_id_o   = head.lce_id;
  assign req_addr_o     = head.addr;
  assign req_size_o     = head.size;
  assign req_lru_way_o  = head.lru_way;
  assign req_non_excl_o = head.non_excl;
  assign req_data_o     = head_data;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_reset;
    else         state_r <= state_n;
  end

  // FSM next state, issue and drop control
  always_comb begin
    state_n   = state_r;
    req_v_o   = 1'b0;
    fifo_yumi = 1'b0;
    error_set = 1'b0;
    unique case (state_r)
      e_reset: state_n = e_ready;
      e_ready: begin
        if (fifo_v) begin
          if (head_error) begin
            state_n   = e_error;
            error_set = 1'b1;
          end else begin
            req_v_o   = ~blocked;
            fifo_yumi = ~blocked & req_yumi_i;
          end
        end
      end
      e_error: begin
        fifo_yumi = fifo_v;
        state_n   = e_ready;
      end
      default: state_n = e_reset;
    endcase
  end

  assign issue = req_v_o & req_yumi_i;

  // Pending set/clear vectors; a set for the same LCE overrides the clear
  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    if (issue & head_cached)
      pending_set = num_lce_lp'(1) << head.lce_id;
    if (pending_clear_v_i)
      pending_clr = num_lce_lp'(1) << pending_clear_lce_i;
  end

  // Per-LCE coherent-transaction-in-flight bits
  always_ff @(posedge clk_i) begin
    if (reset_i) pending_r <= '0;
    else         pending_r <= pending_set | (pending_r & ~pending_clr);
  end

  // Sticky protocol error, raised as the malformed head is detected
  always_ff @(posedge clk_i) begin
    if (reset_i)        error_r <= 1'b0;
    else if (error_set) error_r <= 1'b1;
  end

  assign error_o = error_r;

`ifdef BP_CCE_LCE_REQ_RX_STATS_EN
  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [3:0][31:0] stat_r;

  // Saturating issue counters indexed by request type
  always_ff @(posedge clk_i) begin
    if (reset_i)    stat_r <= '0;
    else if (issue) stat_r[req_type_o] <= sat_inc(stat_r[req_type_o]);
  end

  assign stat_counts_o = stat_r;
`endif

endmodule

// File: tb/tb_bp_cce_lce_req_rx.sv
// Bench for bp_cce_lce_req_rx: directed scenarios followed by random traffic,
// each cycle checked against a message-queue reference model.
module tb_bp_cce_lce_req_rx;
  import bp_me_pkg::*;

  localparam int HW = 51;
  localparam int BW = 512;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, UCR = 2'd2, UCW = 2'd3;
  localparam logic [2:0] SZ8 = 3'd3, SZ64 = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  bp_cce_mode_e         mode;
  logic [HW-1:0]        hdr;
  logic [BW-1:0]        data;
  logic                 lv, lready;
  logic                 rv, yumi;
  bp_cce_req_type_e     rtype;
  logic [1:0]           rlce;
  logic [39:0]          raddr;
  bp_bedrock_msg_size_e rsize;
  logic [2:0]           rlru;
  logic                 rne;
  logic [63:0]          rdata;
  logic                 cv;
  logic [1:0]           cl;
  logic                 err;

  bp_cce_lce_req_rx dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .cce_mode_i          (mode),
    .lce_req_header_i    (hdr),
    .lce_req_data_i      (data),
    .lce_req_v_i         (lv),
    .lce_req_ready_and_o (lready),
    .req_v_o             (rv),
    .req_yumi_i          (yumi),
    .req_type_o          (rtype),
    .req_lce_id_o        (rlce),
    .req_addr_o          (raddr),
    .req_size_o          (rsize),
    .req_lru_way_o       (rlru),
    .req_non_excl_o      (rne),
    .req_data_o          (rdata),
    .pending_clear_v_i   (cv),
    .pending_clear_lce_i (cl),
    .error_o             (err)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [39:0] addr;
    logic [2:0]  size;
    logic [1:0]  lce;
    logic [2:0]  lru;
    logic        ne;
    logic [63:0] dw;
  } msg_t;

  // Reference model state
  msg_t       q[$];
  logic [3:0] pend;
  logic       m_err;
  int         post_reset;
  int         age;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic msg_t mk(input logic [1:0] t, input logic [1:0] l, input logic [2:0] s);
    msg_t m;
    m.typ  = t;
    m.lce  = l;
    m.size = s;
    m.addr = {8'($urandom), $urandom};
    m.lru  = 3'($urandom);
    m.ne   = 1'($urandom);
    m.dw   = {$urandom, $urandom};
    return m;
  endfunction

  // One clock cycle: drive at negedge, compare against the model, advance model
  task automatic step(input logic v, input msg_t m, input logic y, input logic c_v,
                      input logic [1:0] c_l, input logic rst, input bp_cce_mode_e md);
    msg_t h;
    logic cached, badh, blk, ev, er, iss, drop;
    @(negedge clk);
    reset = rst;
    lv    = v;
    hdr   = {m.typ, m.addr, m.size, m.lce, m.lru, m.ne};
    data  = {{14{$urandom}}, m.dw};
    yumi  = y;
    cv    = c_v;
    cl    = c_l;
    mode  = md;
    #1;
    if (rst) begin
      q.delete();
      pend = '0; m_err = 1'b0; post_reset = 1; age = 0;
      return;
    end
    er = (q.size() < 2) && (post_reset == 0);
    ev = 1'b0; cached = 1'b0; badh = 1'b0; blk = 1'b0;
    h = m;
    if (q.size() > 0) begin
      h      = q[0];
      cached = (h.typ == RD) || (h.typ == WR);
      badh   = cached && ((h.size != SZ64) || (md == e_cce_mode_uncached));
      blk    = cached && pend[h.lce] && !(c_v && (c_l == h.lce));
      ev     = !badh && !blk;
    end
    chk("ready", 64'(lready), 64'(er));
    chk("req_v", 64'(rv), 64'(ev));
    chk("error", 64'(err), 64'(m_err));
    if (ev) begin
      chk("type", 64'(rtype), 64'(h.typ));
      chk("lce",  64'(rlce),  64'(h.lce));
      chk("addr", 64'(raddr), 64'(h.addr));
      chk("size", 64'(rsize), 64'(h.size));
      chk("lru",  64'(rlru),  64'(h.lru));
      chk("nexc", 64'(rne),   64'(h.ne));
      chk("data", rdata, h.dw);
    end
    iss  = ev && y;
    drop = badh && (age == 1);
    if (c_v) pend[c_l] = 1'b0;
    if (iss && cached) pend[h.lce] = 1'b1;
    if (badh && age == 0) m_err = 1'b1;
    if (iss || drop) begin
      void'(q.pop_front());
      age = 0;
    end else if (badh) begin
      age++;
    end
    if (v && er) q.push_back(m);
    post_reset = 0;
  endtask

  initial begin
    msg_t nm, m;
    nm = mk(UCR, 2'd0, SZ8);
    pend = '0; m_err = 1'b0; post_reset = 1; age = 0;

    // Reset, then the one-cycle not-ready window
    step(0, nm, 0, 0, 0, 1, e_cce_mode_normal);
    step(0, nm, 0, 0, 0, 1, e_cce_mode_normal);
    step(0, nm, 0, 0, 0, 0, e_cce_mode_normal);
    chk("rst_ready", 64'(lready), 64'd0);

    // Single rd_miss from LCE 1, issued one cycle after acceptance
    m = mk(RD, 2'd1, SZ64);
    step(1, m, 1, 0, 0, 0, e_cce_mode_normal);
    chk("r32_v_accept", 64'(rv), 64'd0);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    chk("r32_v_issue", 64'(rv), 64'd1);
    chk("r32_type", 64'(rtype), 64'(RD));

    // Second rd_miss from LCE 1 stalls until the clear bypasses
    m = mk(RD, 2'd1, SZ64);
    step(1, m, 1, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    chk("r33_blocked", 64'(rv), 64'd0);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 1, 2'd1, 0, e_cce_mode_normal);
    chk("r33_bypass", 64'(rv), 64'd1);

    // Uncached write from the still-pending LCE 1 issues without stall
    m = mk(UCW, 2'd1, SZ8);
    step(1, m, 1, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    chk("r34_v", 64'(rv), 64'd1);
    chk("r34_data", rdata, m.dw);
    step(0, nm, 0, 1, 2'd1, 0, e_cce_mode_normal);

    // Three back-to-back with no yumi: third sees not-ready; then drain
    step(1, mk(UCR, 2'd2, SZ8), 0, 0, 0, 0, e_cce_mode_normal);
    step(1, mk(UCW, 2'd3, SZ64), 0, 0, 0, 0, e_cce_mode_normal);
    step(1, mk(UCR, 2'd0, SZ8), 0, 0, 0, 0, e_cce_mode_normal);
    chk("r35_full", 64'(lready), 64'd0);
    step(0, nm, 0, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);

    // Cached 8B request is dropped with a sticky error; next one issues
    step(1, mk(RD, 2'd2, SZ8), 1, 0, 0, 0, e_cce_mode_normal);
    step(1, mk(WR, 2'd3, SZ64), 1, 0, 0, 0, e_cce_mode_normal);
    chk("r36_nov", 64'(rv), 64'd0);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    chk("r36_err", 64'(err), 64'd1);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    chk("r36_next", 64'(rv), 64'd1);

    // Uncached mode: cached head is an error, uncached head still issues
    step(1, mk(WR, 2'd0, SZ64), 1, 0, 0, 0, e_cce_mode_uncached);
    step(1, mk(UCR, 2'd0, SZ8), 1, 0, 0, 0, e_cce_mode_uncached);
    for (int i = 0; i < 4; i++) step(0, nm, 1, 0, 0, 0, e_cce_mode_uncached);

    // Reset with two buffered and a pending bit set
    step(1, mk(RD, 2'd0, SZ64), 1, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    step(1, mk(UCR, 2'd1, SZ8), 0, 0, 0, 0, e_cce_mode_normal);
    step(1, mk(UCW, 2'd2, SZ8), 0, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 0, 0, 0, 1, e_cce_mode_normal);
    step(0, nm, 0, 0, 0, 0, e_cce_mode_normal);
    chk("r37_ready", 64'(lready), 64'd0);
    chk("r37_empty", 64'(rv), 64'd0);
    chk("r37_err", 64'(err), 64'd0);
    step(1, mk(RD, 2'd0, SZ64), 1, 0, 0, 0, e_cce_mode_normal);
    step(0, nm, 1, 0, 0, 0, e_cce_mode_normal);
    chk("r37_unpend", 64'(rv), 64'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      msg_t rm;
      int   r;
      r  = $urandom_range(0, 149);
      rm = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? SZ8 : SZ64);
      step(1'($urandom_range(0, 1)), rm, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), (r == 0),
           e_cce_mode_normal);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
